// File: rtl/if1_pc_gen.sv
// IF1 PC generator: boot/fetch sequencing, redirect, and next-PC prediction.
// Define IF1_BTB_EN to include the 16-entry direct-mapped BTB with 2-bit counters.
module if1_pc_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_wen,
  input  logic        pc_is_wrong,
  input  logic [31:0] pc_correct,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        ex_br_upd,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc_branch,
  output logic [31:0] if1_pc,
  output logic        if1_valid,
  output logic        if1_branch_bp,
  output logic [31:0] if1_pred_target
);

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  typedef enum logic {BOOT, FETCH} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic [31:0] next_pc;
  logic        fetch_ok;

  // Reset is gated in directly so nothing issues during the reset cycle itself.
  assign fetch_ok        = (state == FETCH) & ~reset;
  assign pc_seq          = pc + 32'd4;
  assign inst_sram_req   = fetch_ok & pc_wen & ~pc_is_wrong;
  assign inst_sram_addr  = pc;
  assign if1_pc          = pc;
  assign if1_valid       = inst_sram_req & inst_sram_addr_ok;

`ifdef IF1_BTB_EN
  logic [15:0] btb_vld;
  logic [25:0] btb_tag [16];
  logic [31:0] btb_tgt [16];
  logic [1:0]  btb_ctr [16];
  logic [3:0]  rd_idx, wr_idx;
  logic        rd_hit, wr_hit;
  logic [1:0]  unused_ex_lsb;

  assign rd_idx          = pc[5:2];
  assign rd_hit          = btb_vld[rd_idx] & (btb_tag[rd_idx] == pc[31:6]);
  assign if1_branch_bp   = fetch_ok & rd_hit & btb_ctr[rd_idx][1];
  assign if1_pred_target = rd_hit ? btb_tgt[rd_idx] : pc_seq;

  assign wr_idx          = ex_pc[5:2];
  assign wr_hit          = btb_vld[wr_idx] & (btb_tag[wr_idx] == ex_pc[31:6]);
  assign unused_ex_lsb   = ex_pc[1:0];

  // Lookup reads the array before this edge, so same-cycle updates appear next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_vld <= '0;
      for (int i = 0; i < 16; i++) btb_ctr[i] <= 2'b01;
    end else if (ex_br_upd) begin
      if (wr_hit) begin
        if (ex_branch) begin
          if (btb_ctr[wr_idx] != 2'b11) btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'd1;
          btb_tgt[wr_idx] <= ex_pc_branch;
        end else if (btb_ctr[wr_idx] != 2'b00) begin
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'd1;
        end
      end else if (ex_branch) begin
        btb_vld[wr_idx] <= 1'b1;
        btb_tag[wr_idx] <= ex_pc[31:6];
        btb_tgt[wr_idx] <= ex_pc_branch;
        btb_ctr[wr_idx] <= 2'b10;
      end
    end
  end
`else
  logic unused_ex;

  assign if1_branch_bp   = 1'b0;
  assign if1_pred_target = pc_seq;
  assign unused_ex       = ^{ex_br_upd, ex_pc, ex_branch, ex_pc_branch};
`endif

  always_comb begin
    next_pc = pc;
    if (pc_wen & pc_is_wrong) next_pc = pc_correct;
    else if (if1_valid)       next_pc = if1_branch_bp ? if1_pred_target : pc_seq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= FETCH;
      pc    <= next_pc;
    end
  end

endmodule

// File: tb/tb_if1_pc_gen.sv
// Table-driven bench for if1_pc_gen with a scoreboard queue of expected outputs.
// BTB expectations switch on IF1_BTB_EN.
module tb_if1_pc_gen;

`ifdef IF1_BTB_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif
  localparam logic [31:0] T = 32'h1C00_0080;

  logic        clk = 1'b0;
  logic        reset, pc_wen, pc_is_wrong, inst_sram_addr_ok;
  logic [31:0] pc_correct, ex_pc, ex_pc_branch;
  logic        ex_br_upd, ex_branch;
  logic        inst_sram_req, if1_valid, if1_branch_bp;
  logic [31:0] inst_sram_addr, if1_pc, if1_pred_target;

  int checks = 0;
  int failures = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  if1_pc_gen dut (
    .clk(clk), .reset(reset), .pc_wen(pc_wen), .pc_is_wrong(pc_is_wrong),
    .pc_correct(pc_correct), .inst_sram_req(inst_sram_req),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .ex_br_upd(ex_br_upd), .ex_pc(ex_pc), .ex_branch(ex_branch),
    .ex_pc_branch(ex_pc_branch), .if1_pc(if1_pc), .if1_valid(if1_valid),
    .if1_branch_bp(if1_branch_bp), .if1_pred_target(if1_pred_target)
  );

  typedef struct {
    logic        rst, wen, wrong, ok, upd, br;
    logic [31:0] corr, expc, extgt;
    logic        e_req, e_val, e_bp;
    logic [31:0] e_addr, e_tgt;
  } vec_t;

  typedef struct {
    logic        req, val, bp;
    logic [31:0] addr, tgt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[20];

  function automatic vec_t mkv(logic rst, logic wen, logic wrong, logic ok,
                               logic [31:0] corr, logic upd, logic br,
                               logic [31:0] expc, logic [31:0] extgt,
                               logic e_req, logic e_val, logic e_bp,
                               logic [31:0] e_addr, logic [31:0] e_tgt);
    vec_t v;
    v.rst = rst; v.wen = wen; v.wrong = wrong; v.ok = ok; v.corr = corr;
    v.upd = upd; v.br = br; v.expc = expc; v.extgt = extgt;
    v.e_req = e_req; v.e_val = e_val; v.e_bp = e_bp;
    v.e_addr = e_addr; v.e_tgt = e_tgt;
    return v;
  endfunction

  // No BTB traffic: bp = 0 and the predicted target is the sequential PC.
  function automatic vec_t mk(logic rst, logic wen, logic wrong, logic ok,
                              logic [31:0] corr, logic e_req, logic e_val,
                              logic [31:0] e_addr);
    return mkv(rst, wen, wrong, ok, corr, 1'b0, 1'b0, 32'h0, 32'h0,
               e_req, e_val, 1'b0, e_addr, e_addr + 32'd4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", name, step_no, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    reset = v.rst; pc_wen = v.wen; pc_is_wrong = v.wrong; inst_sram_addr_ok = v.ok;
    pc_correct = v.corr; ex_br_upd = v.upd; ex_branch = v.br;
    ex_pc = v.expc; ex_pc_branch = v.extgt;
    e.req = v.e_req; e.val = v.e_val; e.bp = v.e_bp; e.addr = v.e_addr; e.tgt = v.e_tgt;
    sb.push_back(e);
    #3;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("req",    {31'd0, inst_sram_req}, {31'd0, e.req});
      chk("valid",  {31'd0, if1_valid},     {31'd0, e.val});
      chk("bp",     {31'd0, if1_branch_bp}, {31'd0, e.bp});
      chk("addr",   inst_sram_addr,         e.addr);
      chk("if1_pc", if1_pc,                 e.addr);
      chk("tgt",    if1_pred_target,        e.tgt);
    end
    step_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout step=%0d got=running want=finished", step_no);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pc_wen = 1'b0; pc_is_wrong = 1'b0; inst_sram_addr_ok = 1'b0;
    pc_correct = '0; ex_br_upd = 1'b0; ex_branch = 1'b0; ex_pc = '0; ex_pc_branch = '0;
    @(posedge clk);

    //            rst wen wrg ok  corr          req val addr
    tbl[0]  = mk(1, 1, 0, 1, 32'h0,         0, 0, 32'h1C00_0000);
    tbl[1]  = mk(0, 1, 0, 1, 32'h0,         0, 0, 32'h1C00_0000);
    tbl[2]  = mk(0, 1, 0, 1, 32'h0,         1, 1, 32'h1C00_0000);
    tbl[3]  = mk(0, 1, 0, 1, 32'h0,         1, 1, 32'h1C00_0004);
    tbl[4]  = mk(0, 1, 0, 1, 32'h0,         1, 1, 32'h1C00_0008);
    tbl[5]  = mk(0, 0, 0, 1, 32'h0,         0, 0, 32'h1C00_000C);
    tbl[6]  = mk(0, 0, 0, 1, 32'h0,         0, 0, 32'h1C00_000C);
    tbl[7]  = mk(0, 0, 0, 1, 32'h0,         0, 0, 32'h1C00_000C);
    tbl[8]  = mk(0, 1, 0, 0, 32'h0,         1, 0, 32'h1C00_000C);
    tbl[9]  = mk(0, 1, 1, 0, 32'h1C00_0100, 0, 0, 32'h1C00_000C);
    tbl[10] = mk(0, 1, 0, 1, 32'h0,         1, 1, 32'h1C00_0100);
    tbl[11] = mk(0, 1, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h1C00_0104);
    tbl[12] = mk(0, 1, 0, 1, 32'h0,         1, 1, 32'hFFFF_FFFC);
    tbl[13] = mk(0, 1, 0, 1, 32'h0,         1, 1, 32'h0000_0000);
    tbl[14] = mk(0, 0, 1, 1, 32'hDEAD_0000, 0, 0, 32'h0000_0004);
    tbl[15] = mk(0, 1, 0, 1, 32'h0,         1, 1, 32'h0000_0004);
    tbl[16] = mk(1, 1, 0, 1, 32'h0,         0, 0, 32'h0000_0008);
    tbl[17] = mk(1, 1, 1, 1, 32'h1234_5678, 0, 0, 32'h1C00_0000);
    tbl[18] = mk(0, 1, 1, 1, 32'h1C00_0200, 0, 0, 32'h1C00_0000);
    tbl[19] = mk(0, 1, 0, 1, 32'h0,         1, 1, 32'h1C00_0200);
    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // Allocation alongside a redirect, then counter walk on entry 0x1C000010.
    apply(mkv(1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h1C00_0204, 32'h1C00_0208));
    apply(mkv(0, 1, 1, 0, 32'h1C00_0010, 1, 1, 32'h1C00_0010, T,
              0, 0, 0, 32'h1C00_0000, 32'h1C00_0004));
    apply(mkv(0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0,
              0, 0, B, 32'h1C00_0010, B ? T : 32'h1C00_0014));
    apply(mkv(0, 1, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0,
              1, 1, B, 32'h1C00_0010, B ? T : 32'h1C00_0014));
    apply(mkv(0, 1, 1, 1, 32'h1C00_0010, 0, 0, 32'h0, 32'h0,
              0, 0, 0, B ? T : 32'h1C00_0014, B ? T + 32'd4 : 32'h1C00_0018));
    // Same-cycle update must not affect this cycle's prediction.
    apply(mkv(0, 0, 0, 1, 32'h0, 1, 1, 32'h1C00_0010, T,
              0, 0, B, 32'h1C00_0010, B ? T : 32'h1C00_0014));
    apply(mkv(0, 0, 0, 1, 32'h0, 1, 0, 32'h1C00_0010, T,
              0, 0, B, 32'h1C00_0010, B ? T : 32'h1C00_0014));
    apply(mkv(0, 0, 0, 1, 32'h0, 1, 0, 32'h1C00_0010, T,
              0, 0, B, 32'h1C00_0010, B ? T : 32'h1C00_0014));
    apply(mkv(0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0,
              0, 0, 0, 32'h1C00_0010, B ? T : 32'h1C00_0014));
    apply(mkv(0, 1, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0,
              1, 1, 0, 32'h1C00_0010, B ? T : 32'h1C00_0014));
    // Drive counter to 00, then a taken update on a hit must only step to 01.
    apply(mkv(0, 0, 0, 1, 32'h0, 1, 0, 32'h1C00_0010, T,
              0, 0, 0, 32'h1C00_0014, 32'h1C00_0018));
    apply(mkv(0, 0, 0, 1, 32'h0, 1, 1, 32'h1C00_0010, T,
              0, 0, 0, 32'h1C00_0014, 32'h1C00_0018));
    apply(mkv(0, 1, 1, 1, 32'h1C00_0010, 0, 0, 32'h0, 32'h0,
              0, 0, 0, 32'h1C00_0014, 32'h1C00_0018));
    apply(mkv(0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0,
              0, 0, 0, 32'h1C00_0010, B ? T : 32'h1C00_0014));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if1_pc_gen.md
IF1_PC_GEN -- requirements
Module: if1_pc_gen

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: pc_wen  in  1  PC advance enable from hazard control; 0 = hold.
REQ-004 SHALL have ports: pc_is_wrong  in  1  redirect request.
REQ-005 SHALL have ports: pc_correct  in  32  redirect target.
REQ-006 SHALL have ports: inst_sram_req  out  1  fetch request; inst_sram_addr  out  32  fetch address; inst_sram_addr_ok  in  1  address accepted.
REQ-007 SHALL have ports: ex_br_upd  in  1  branch resolved in EX; ex_pc  in  32; ex_branch  in  1  actual taken; ex_pc_branch  in  32  actual target.
REQ-008 SHALL have ports: if1_pc  out  32  PC of the fetch accepted this cycle; if1_valid  out  1  accept strobe; if1_branch_bp  out  1  predicted taken; if1_pred_target  out  32  predicted target.

Function
REQ-009 SHALL implement FSM states BOOT and FETCH; reset enters BOOT; BOOT -> FETCH unconditionally after one cycle; FETCH has no exit except reset.
REQ-010 SHALL drive inst_sram_req = 0 in BOOT; in FETCH inst_sram_req = pc_wen & ~pc_is_wrong.
REQ-011 SHALL drive inst_sram_addr = pc register, if1_pc = pc register, if1_valid = inst_sram_req & inst_sram_addr_ok.
REQ-012 SHALL update the pc register with priority: (1) pc_wen & pc_is_wrong -> pc_correct, regardless of addr_ok or FSM state; (2) if1_valid -> predicted next PC; (3) otherwise hold.
REQ-013 SHALL compute predicted next PC = if1_pred_target when if1_branch_bp = 1, else pc + 4, wrapping modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-014 SHALL hold PC and issue no accept while pc_wen = 0, even if addr_ok = 1.
REQ-015 SHALL keep a 16-entry direct-mapped BTB: index pc[5:2], tag pc[31:6], valid bit, 32-bit target, 2-bit saturating counter.
REQ-016 SHALL predict (combinationally, from the current pc register) if1_branch_bp = valid & tag match & ctr[1]; if1_pred_target = entry target when hit, else pc + 4.
REQ-017 SHALL update the BTB on ex_br_upd, indexed by ex_pc: hit & taken -> ctr saturating +1 (max 11), target <= ex_pc_branch; hit & not taken -> ctr saturating -1 (min 00); miss & taken -> allocate, valid = 1, tag, target, ctr = 10; miss & not taken -> no change.
REQ-018 SHALL make a BTB write visible from the next cycle; same-cycle lookup and update of one index reads the old entry.
REQ-019 SHALL apply a simultaneous redirect and BTB update both in the same cycle, independently.

Reset
REQ-020 SHALL on reset set pc = 0x1C000000, FSM = BOOT, all BTB valid bits = 0, all counters = 01; reset overrides every other input, including mid-redirect.
REQ-021 SHALL hold during and one cycle after reset: inst_sram_req = 0, if1_valid = 0, if1_branch_bp = 0.

Configuration
REQ-022 SHALL with macro IF1_BTB_EN defined include the BTB as in REQ-015..REQ-019.
REQ-023 SHALL with IF1_BTB_EN undefined omit all BTB storage: if1_branch_bp = 0, if1_pred_target = pc + 4, ex_br_upd ignored; all other behaviour unchanged.

Verification
REQ-024 SHALL cover: reset released, addr_ok = 1, pc_wen = 1 -> no req in first cycle, then accepts at 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles.
REQ-025 SHALL cover: pc_wen = 0 for 3 cycles with addr_ok = 1 -> pc held, if1_valid = 0, no advance.
REQ-026 SHALL cover: pc_is_wrong = 1, pc_correct = 0x1C000100, pc_wen = 1, addr_ok = 0 -> next-cycle inst_sram_addr = 0x1C000100.
REQ-027 SHALL cover (BTB_EN): ex_br_upd taken, ex_pc = 0x1C000010, target 0x1C000080 -> next fetch of 0x1C000010 gives bp = 1, target 0x1C000080; two not-taken updates -> bp = 0.
REQ-028 SHALL cover: pc = 0xFFFFFFFC accepted, no BTB hit -> next pc 0x00000000.
REQ-029 SHALL cover: reset asserted during a redirect cycle -> pc = 0x1C000000, BTB cleared.
